// File: rtl/hamming_pkg.sv
// Shared definitions for the parametrised UART-fed Hamming decoder: code
// geometry helpers, receiver FSM states and the UART idle level.
package hamming_pkg;

  localparam logic UART_IDLE_LVL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PAR    = 3'd3,
    ST_STOP   = 3'd4,
    ST_DECODE = 3'd5
  } uart_state_e;

  function automatic int cw_len(input int r);
    return (1 << r) - 1;
  endfunction

  function automatic int data_len(input int r);
    return cw_len(r) - r;
  endfunction

  function automatic bit is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

endpackage

// File: rtl/hamming_uart_decoder_p_syndrome_corr.sv
// Combinational Hamming syndrome / single-bit correction. Codeword bit i-1
// carries position i; data bits are the non-power-of-two positions, ascending.
module hamming_syndrome_corr
  import hamming_pkg::*;
#(
  parameter  int R_BITS = 4,
  localparam int N      = cw_len(R_BITS),
  localparam int K      = data_len(R_BITS)
) (
  input  logic [N-1:0]      cw,
  input  logic              par_bit,
  output logic [K-1:0]      data_corr,
  output logic [K-1:0]      data_raw,
  output logic [R_BITS-1:0] syndrome,
  output logic              pe
);

  function automatic int data_pos(input int k);
    int cnt;
    int res;
    cnt = 0;
    res = 1;
    for (int p = 1; p <= N; p++) begin
      if (!is_pow2(p)) begin
        if (cnt == k) res = p;
        cnt++;
      end
    end
    return res;
  endfunction

  always_comb begin
    syndrome = '0;
    for (int p = 1; p <= N; p++) begin
      if (cw[p-1]) syndrome = syndrome ^ R_BITS'(p);
    end
  end

  assign pe = (^cw) ^ par_bit;

  // A syndrome naming a parity position flips nothing in the data field.
  for (genvar k = 0; k < K; k++) begin : g_map
    localparam int P = data_pos(k);
    assign data_raw[k]  = cw[P-1];
    assign data_corr[k] = cw[P-1] ^ (syndrome == R_BITS'(P));
  end

endmodule

// File: rtl/hamming_uart_decoder_p.sv
// UART-fed Hamming (2^R-1, 2^R-1-R) decoder with single-error correction.
// Define HAMMING_SECDED_EN to add the overall-parity bit and double-error detection.
module hamming_uart_decoder_p
  import hamming_pkg::*;
#(
  parameter int R_BITS  = 4,
  parameter int CLK_DIV = 16
) (
  input  logic                        clk_de,
  input  logic                        rst_de,
  input  logic                        msg_in_de,
  output logic [data_len(R_BITS)-1:0] msg_out_de,
  output logic                        msg_valid_de,
  output logic                        err_corr_de,
  output logic                        err_frame_de
`ifdef HAMMING_SECDED_EN
  ,
  output logic                        err_uncorr_de
`endif
);

  localparam int N     = cw_len(R_BITS);
  localparam int K     = data_len(R_BITS);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(N + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(N - 1);

  logic              sync_p0, sync_p1, sync_p2;
  logic              line, fall;
  uart_state_e       state;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic              tick_full, tick_half;
  logic [N-1:0]      cw_p0;
  logic              par_bit;
  logic [K-1:0]      data_corr, data_raw;
  logic [R_BITS-1:0] syndrome;
  logic              pe;

  // Stage p0..p2: two-flop synchroniser plus one history flop for edge detect
  always_ff @(posedge clk_de) begin
    if (rst_de) begin
      sync_p0 <= UART_IDLE_LVL;
      sync_p1 <= UART_IDLE_LVL;
      sync_p2 <= UART_IDLE_LVL;
    end else begin
      sync_p0 <= msg_in_de;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign line      = sync_p1;
  assign fall      = (sync_p2 == UART_IDLE_LVL) && (sync_p1 != UART_IDLE_LVL);
  assign tick_full = (div_cnt == DIV_LAST);
  assign tick_half = (div_cnt == HALF_LAST);

  always_ff @(posedge clk_de) begin
    if (state == ST_DATA && tick_full) cw_p0 <= {line, cw_p0[N-1:1]};
  end

`ifdef HAMMING_SECDED_EN
  logic par_p0;
  always_ff @(posedge clk_de) begin
    if (state == ST_PAR && tick_full) par_p0 <= line;
  end
  assign par_bit = par_p0;
`else
  assign par_bit = 1'b0;
  logic [K-1:0] data_raw_unused;
  logic         pe_unused;
  assign data_raw_unused = data_raw;
  assign pe_unused       = pe;
`endif

  hamming_syndrome_corr #(
    .R_BITS (R_BITS)
  ) u_syndrome_corr (
    .cw        (cw_p0),
    .par_bit   (par_bit),
    .data_corr (data_corr),
    .data_raw  (data_raw),
    .syndrome  (syndrome),
    .pe        (pe)
  );

  // Receiver FSM; DECODE registers the result so valid lands one cycle later
  always_ff @(posedge clk_de) begin
    if (rst_de) begin
      state        <= ST_IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      msg_out_de   <= '0;
      msg_valid_de <= 1'b0;
      err_corr_de  <= 1'b0;
      err_frame_de <= 1'b0;
`ifdef HAMMING_SECDED_EN
      err_uncorr_de <= 1'b0;
`endif
    end else begin
      msg_valid_de <= 1'b0;
      err_corr_de  <= 1'b0;
      err_frame_de <= 1'b0;
`ifdef HAMMING_SECDED_EN
      err_uncorr_de <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          if (fall) state <= ST_START;
        end
        ST_START: begin
          if (tick_half) begin
            div_cnt <= '0;
            state   <= (line == UART_IDLE_LVL) ? ST_IDLE : ST_DATA;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        ST_DATA: begin
          if (tick_full) begin
            div_cnt <= '0;
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (bit_cnt == BIT_LAST) begin
`ifdef HAMMING_SECDED_EN
              state <= ST_PAR;
`else
              state <= ST_STOP;
`endif
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
`ifdef HAMMING_SECDED_EN
        ST_PAR: begin
          if (tick_full) begin
            div_cnt <= '0;
            state   <= ST_STOP;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
`endif
        ST_STOP: begin
          if (tick_full) begin
            div_cnt <= '0;
            if (line != UART_IDLE_LVL) begin
              err_frame_de <= 1'b1;
              state        <= ST_IDLE;
            end else begin
              state <= ST_DECODE;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        ST_DECODE: begin
          state        <= ST_IDLE;
          msg_valid_de <= 1'b1;
`ifdef HAMMING_SECDED_EN
          if (syndrome != '0 && !pe) begin
            msg_out_de    <= data_raw;
            err_uncorr_de <= 1'b1;
          end else begin
            msg_out_de  <= data_corr;
            err_corr_de <= (syndrome != '0) || pe;
          end
`else
          msg_out_de  <= data_corr;
          err_corr_de <= (syndrome != '0);
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_uart_decoder_p.sv
// Directed bench for hamming_uart_decoder_p: (15,11) instance at CLK_DIV=16
// and a (7,4) instance at CLK_DIV=4 for back-to-back framing.
module tb_hamming_uart_decoder_p;

  localparam int DIV  = 16;
  localparam int DIV2 = 4;
`ifdef HAMMING_SECDED_EN
  localparam bit SECDED = 1'b1;
`else
  localparam bit SECDED = 1'b0;
`endif
  localparam int GAP_B = (SECDED ? 10 : 9) * DIV2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        line_a = 1'b1;
  logic        line_b = 1'b1;
  logic [10:0] msg_a;
  logic        vld_a, corr_a, ferr_a;
  logic [3:0]  msg_b;
  logic        vld_b, corr_b, ferr_b;
`ifdef HAMMING_SECDED_EN
  logic        unc_a, unc_b;
`endif

  always #5 clk = ~clk;

  hamming_uart_decoder_p #(.R_BITS(4), .CLK_DIV(DIV)) dut_a (
    .clk_de       (clk),
    .rst_de       (rst),
    .msg_in_de    (line_a),
    .msg_out_de   (msg_a),
    .msg_valid_de (vld_a),
    .err_corr_de  (corr_a),
    .err_frame_de (ferr_a)
`ifdef HAMMING_SECDED_EN
    ,
    .err_uncorr_de (unc_a)
`endif
  );

  hamming_uart_decoder_p #(.R_BITS(3), .CLK_DIV(DIV2)) dut_b (
    .clk_de       (clk),
    .rst_de       (rst),
    .msg_in_de    (line_b),
    .msg_out_de   (msg_b),
    .msg_valid_de (vld_b),
    .err_corr_de  (corr_b),
    .err_frame_de (ferr_b)
`ifdef HAMMING_SECDED_EN
    ,
    .err_uncorr_de (unc_b)
`endif
  );

  int          cyc = 0;
  int          va = 0, fa = 0, vb = 0, fb = 0;
  logic [10:0] last_msg_a = '0;
  logic        last_corr_a = 1'b0;
  logic        last_unc_a = 1'b0;
  int          t_b [4];
  logic [3:0]  m_b [4];
  logic        c_b [4];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (vld_a) begin
      va++;
      last_msg_a  = msg_a;
      last_corr_a = corr_a;
`ifdef HAMMING_SECDED_EN
      last_unc_a  = unc_a;
`endif
    end
    if (ferr_a) fa++;
    if (vld_b) begin
      if (vb < 4) begin
        t_b[vb] = cyc;
        m_b[vb] = msg_b;
        c_b[vb] = corr_b;
`ifdef HAMMING_SECDED_EN
        c_b[vb] = corr_b | unc_b;
`endif
      end
      vb++;
    end
    if (ferr_b) fb++;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit to_b, input logic v, input int ncyc);
    if (to_b) line_b = v;
    else      line_a = v;
    repeat (ncyc) @(negedge clk);
  endtask

  task automatic send_frame(input bit to_b, input logic [14:0] cw, input int n,
                            input logic p, input logic stop);
    int div;
    div = to_b ? DIV2 : DIV;
    drive(to_b, 1'b0, div);
    for (int i = 0; i < n; i++) drive(to_b, cw[i], div);
    if (SECDED) drive(to_b, p, div);
    drive(to_b, stop, div);
  endtask

  task automatic run_a(input string tag, input logic [14:0] cw, input logic p,
                       input logic [10:0] exp_msg, input logic exp_corr, input logic exp_unc);
    int va0;
    va0 = va;
    send_frame(1'b0, cw, 15, p, 1'b1);
    drive(1'b0, 1'b1, 40);
    check_eq({tag, "_vld"},  va - va0, 1);
    check_eq({tag, "_msg"},  last_msg_a, exp_msg);
    check_eq({tag, "_corr"}, last_corr_a, exp_corr);
`ifdef HAMMING_SECDED_EN
    check_eq({tag, "_unc"},  last_unc_a, exp_unc);
`else
    if (exp_unc) check_eq({tag, "_unc_nosecded"}, 0, 1);
`endif
  endtask

  initial begin
    int va0, fa0, vb0;
    repeat (4) @(negedge clk);
    check_eq("rst_msg",   msg_a, 0);
    check_eq("rst_vld",   vld_a, 0);
    check_eq("rst_corr",  corr_a, 0);
    check_eq("rst_ferr",  ferr_a, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    run_a("zero",  15'h0000, 1'b0, 11'h000, 1'b0, 1'b0);
    run_a("ones",  15'h7FFF, 1'b1, 11'h7FF, 1'b0, 1'b0);
    run_a("pos5",  15'h0010, 1'b0, 11'h000, 1'b1, 1'b0);
    run_a("pos8",  15'h0080, 1'b0, 11'h000, 1'b1, 1'b0);
    run_a("pos15", 15'h008B, 1'b1, 11'h400, 1'b1, 1'b0);
`ifdef HAMMING_SECDED_EN
    run_a("dbl35", 15'h0014, 1'b0, 11'h003, 1'b0, 1'b1);
`else
    // syndrome 3^5=6 flips data bit 2 on top of bits 0 and 1
    run_a("dbl35", 15'h0014, 1'b0, 11'h007, 1'b1, 1'b0);
`endif

    va0 = va;
    fa0 = fa;
    send_frame(1'b0, 15'h0007, 15, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 40);
    check_eq("ferr_pulse", fa - fa0, 1);
    check_eq("ferr_novld", va - va0, 0);
    check_eq("ferr_hold",  msg_a, SECDED ? 11'h003 : 11'h007);
    run_a("after_ferr", 15'h408B, 1'b1, 11'h400, 1'b0, 1'b0);

    va0 = va;
    fa0 = fa;
    drive(1'b0, 1'b0, 4);
    drive(1'b0, 1'b1, 60);
    check_eq("glitch_vld",  va - va0, 0);
    check_eq("glitch_ferr", fa - fa0, 0);

    va0 = va;
    fa0 = fa;
    drive(1'b0, 1'b0, DIV * 7 + DIV / 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b1, 4 * DIV);
    check_eq("abort_vld",  va - va0, 0);
    check_eq("abort_ferr", fa - fa0, 0);
    check_eq("abort_msg",  msg_a, 0);
    run_a("after_rst", 15'h0007, 1'b1, 11'h001, 1'b0, 1'b0);

`ifdef HAMMING_SECDED_EN
    run_a("pflip", 15'h0000, 1'b1, 11'h000, 1'b1, 1'b0);
`endif

    vb0 = vb;
    send_frame(1'b1, 15'h007F, 7, 1'b1, 1'b1);
    send_frame(1'b1, 15'h0000, 7, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 40);
    check_eq("b2b_cnt",   vb - vb0, 2);
    check_eq("b2b_msg0",  m_b[0], 4'hF);
    check_eq("b2b_msg1",  m_b[1], 4'h0);
    check_eq("b2b_err0",  c_b[0], 0);
    check_eq("b2b_err1",  c_b[1], 0);
    check_eq("b2b_gap",   t_b[1] - t_b[0], GAP_B);
    check_eq("b2b_ferr",  fb, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
